cache_line_responder: RTL and testbench

- Bus-side responder for the cache line-fill/writeback protocol: services CacheBusRW/CacheBusAdr requests, drives BeatCount/SelBusBeat, assembles FetchBuffer, and returns CacheBusAck.
- Backed by an internal beat-addressed memory array.
- Used as a standalone cache test harness and as a simple tightly-coupled memory for cache bring-up, replacing the AHB path.

---
 rtl/cache_line_responder_if.sv | 40 ++++
 rtl/cache_line_responder.sv | 197 +++++++++++++++++++
 tb/tb_cache_line_responder.sv | 329 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cache_line_responder_if.sv
// cache_line_responder_if: cache <-> responder line-fill / writeback bus.
// The cache drives the request side (master); the responder drives beat
// sequencing, the assembled fetch line and the ack (slave).
// Optional macro CACHE_RESP_ERR_EN adds the BusErr signal.
interface cache_line_responder_if #(
    parameter int PA_BITS = 32,
    parameter int LINELEN = 512,
    parameter int BEATLEN = 64
);
    localparam int BEAT_CNT_W = $clog2(LINELEN / BEATLEN);

    logic [1:0]            CacheBusRW;
    logic [PA_BITS-1:0]    CacheBusAdr;
    logic [BEATLEN-1:0]    WriteBeatData;
    logic                  FlushStage;
    logic [BEAT_CNT_W-1:0] BeatCount;
    logic                  SelBusBeat;
    logic [LINELEN-1:0]    FetchBuffer;
    logic                  CacheBusAck;
    logic                  BusBusy;
`ifdef CACHE_RESP_ERR_EN
    logic                  BusErr;
`endif

    modport master (
        output CacheBusRW, CacheBusAdr, WriteBeatData, FlushStage,
        input  BeatCount, SelBusBeat, FetchBuffer, CacheBusAck, BusBusy
`ifdef CACHE_RESP_ERR_EN
        , input BusErr
`endif
    );

    modport slave (
        input  CacheBusRW, CacheBusAdr, WriteBeatData, FlushStage,
        output BeatCount, SelBusBeat, FetchBuffer, CacheBusAck, BusBusy
`ifdef CACHE_RESP_ERR_EN
        , output BusErr
`endif
    );
endinterface

// File: rtl/cache_line_responder.sv
// cache_line_responder: bus-side responder for cache line fills and
// writebacks, backed by a beat-addressed internal memory. A request waits
// LATENCY cycles, then moves one beat per cycle and acks in the last beat.
// Optional macro CACHE_RESP_ERR_EN: out-of-range line indices no longer wrap;
// reads return zeros, writes are dropped and BusErr pulses with the ack.
module cache_line_responder #(
    parameter int PA_BITS  = 32,
    parameter int LINELEN  = 512,
    parameter int BEATLEN  = 64,
    parameter int MEMBEATS = 4096,
    parameter int LATENCY  = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    cache_line_responder_if.slave bus
);
    localparam int BEATSPERLINE = LINELEN / BEATLEN;
    localparam int BC_W         = $clog2(BEATSPERLINE);
    localparam int OFF_W        = $clog2(LINELEN / 8);
    localparam int MA_W         = $clog2(MEMBEATS);
    localparam int LINE_W       = MA_W - BC_W;

    localparam logic [BC_W-1:0] BEAT_LAST = BC_W'(BEATSPERLINE - 1);
    localparam logic [3:0]      LAT_LAST  = 4'(LATENCY - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_RDBURST,
        S_WRBURST,
        S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [BC_W-1:0]     beat_q, beat_d;
    logic [3:0]          lat_q, lat_d;
    logic [LINE_W-1:0]   line_q, line_d;
    logic                wr_q, wr_d;
    logic [LINELEN-1:0]  fetch_q, fetch_d;
`ifdef CACHE_RESP_ERR_EN
    logic                err_q, err_d;
`endif

    logic [BEATLEN-1:0]  mem_q [MEMBEATS];
    logic [MA_W-1:0]     beat_addr;
    logic [BEATLEN-1:0]  rd_data;
    logic                mem_we;
    logic                ack;
    logic                sel;

    // Offset bits are ignored by design; without the error feature the bits
    // above the wrapped line index are ignored too.
    logic unused_adr;
    assign unused_adr = ^bus.CacheBusAdr;

    // Beat address is the latched line index with the beat counter appended;
    // keeping only MA_W bits gives the modulo-MEMBEATS wrap for free.
    assign beat_addr = {line_q, beat_q};

`ifdef CACHE_RESP_ERR_EN
    assign rd_data = err_q ? '0 : mem_q[beat_addr];
`else
    assign rd_data = mem_q[beat_addr];
`endif

    // Next-state, beat sequencing, fetch assembly and output decode.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path can
        // leave one unassigned, which would otherwise infer a latch.
        state_d = state_q;
        beat_d  = beat_q;
        lat_d   = lat_q;
        line_d  = line_q;
        wr_d    = wr_q;
        fetch_d = fetch_q;
`ifdef CACHE_RESP_ERR_EN
        err_d   = err_q;
`endif
        mem_we  = 1'b0;
        ack     = 1'b0;
        sel     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.CacheBusRW != 2'b00) begin
                    line_d = bus.CacheBusAdr[OFF_W +: LINE_W];
                    // Writeback wins when both bits are set.
                    wr_d   = bus.CacheBusRW[0];
`ifdef CACHE_RESP_ERR_EN
                    err_d  = |bus.CacheBusAdr[PA_BITS-1:OFF_W+LINE_W];
`endif
                    beat_d = '0;
                    lat_d  = '0;
                    if (LATENCY > 0) begin
                        state_d = S_WAIT;
                    end else begin
                        state_d = bus.CacheBusRW[0] ? S_WRBURST : S_RDBURST;
                    end
                end
            end

            S_WAIT: begin
                if (bus.FlushStage) begin
                    state_d = S_IDLE;
                    lat_d   = '0;
                end else if (lat_q == LAT_LAST) begin
                    state_d = wr_q ? S_WRBURST : S_RDBURST;
                    lat_d   = '0;
                end else begin
                    lat_d = lat_q + 4'd1;
                end
            end

            S_RDBURST: begin
                fetch_d[beat_q*BEATLEN +: BEATLEN] = rd_data;
                if (beat_q == BEAT_LAST) begin
                    ack     = 1'b1;
                    beat_d  = '0;
                    state_d = S_DONE;
                end else begin
                    beat_d = beat_q + 1'b1;
                end
            end

            S_WRBURST: begin
                sel = 1'b1;
`ifdef CACHE_RESP_ERR_EN
                mem_we = ~err_q;
`else
                mem_we = 1'b1;
`endif
                if (beat_q == BEAT_LAST) begin
                    ack     = 1'b1;
                    beat_d  = '0;
                    state_d = S_DONE;
                end else begin
                    beat_d = beat_q + 1'b1;
                end
            end

            S_DONE: begin
                beat_d  = '0;
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
                beat_d  = '0;
            end
        endcase
    end

    // Control and fetch-buffer registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples the pre-edge values regardless of statement order.
        if (reset) begin
            state_q <= S_IDLE;
            beat_q  <= '0;
            lat_q   <= '0;
            line_q  <= '0;
            wr_q    <= 1'b0;
            fetch_q <= '0;
`ifdef CACHE_RESP_ERR_EN
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            lat_q   <= lat_d;
            line_q  <= line_d;
            wr_q    <= wr_d;
            fetch_q <= fetch_d;
`ifdef CACHE_RESP_ERR_EN
            err_q   <= err_d;
`endif
        end
    end

    // Backing memory write port.
    always_ff @(posedge clk) begin
        // NOTE: the memory array has no reset; contents survive reset and
        // only the write enable is qualified by it.
        if (mem_we && !reset) begin
            mem_q[beat_addr] <= bus.WriteBeatData;
        end
    end

    assign bus.BeatCount   = beat_q;
    assign bus.SelBusBeat  = sel;
    assign bus.FetchBuffer = fetch_q;
    assign bus.CacheBusAck = ack;
    assign bus.BusBusy     = (state_q != S_IDLE);
`ifdef CACHE_RESP_ERR_EN
    assign bus.BusErr      = ack & err_q;
`endif
endmodule

// File: tb/tb_cache_line_responder.sv
// tb_cache_line_responder: self-checking bench for cache_line_responder.
// A line-level memory model (associative array of beats) and a fetch-buffer
// model predict every result; BusErr checks apply when CACHE_RESP_ERR_EN is set.
module tb_cache_line_responder;
    localparam int PA_BITS    = 32;
    localparam int LINELEN    = 512;
    localparam int BEATLEN    = 64;
    localparam int MEMBEATS   = 4096;
    localparam int LATENCY    = 2;
    localparam int BPL        = LINELEN / BEATLEN;
    localparam int LINE_BYTES = LINELEN / 8;
    localparam int ACK_CYC    = LATENCY + BPL;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    cache_line_responder_if #(.PA_BITS(PA_BITS), .LINELEN(LINELEN), .BEATLEN(BEATLEN)) bif();

    cache_line_responder #(
        .PA_BITS(PA_BITS), .LINELEN(LINELEN), .BEATLEN(BEATLEN),
        .MEMBEATS(MEMBEATS), .LATENCY(LATENCY)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bif)
    );

    // Cache side: writeback data is selected combinationally by BeatCount.
    logic [BEATLEN-1:0] wr_beats [BPL];
    assign bif.WriteBeatData = wr_beats[bif.BeatCount];

    int asserts = 0;
    int fails   = 0;

    // Reference model.
    logic [BEATLEN-1:0] mdl_mem [int];
    logic [BEATLEN-1:0] mdl_fb  [BPL];

    // Observations of the last transaction.
    int                 obs_ack_cyc;
    int                 obs_bc_bad;
    int                 obs_sel_bad;
    int                 obs_busy_bad;
    int                 obs_extra_ack;
    int                 obs_done_bc;
    logic               obs_err;
    logic [BEATLEN-1:0] obs_beats [BPL];

    function automatic int beat_of(input logic [PA_BITS-1:0] adr, input int i);
        longint line;
        line = longint'(adr / LINE_BYTES);
        return int'((line * BPL + i) % MEMBEATS);
    endfunction

    function automatic bit is_err(input logic [PA_BITS-1:0] adr);
`ifdef CACHE_RESP_ERR_EN
        return (adr / LINE_BYTES) >= (MEMBEATS / BPL);
`else
        return (adr == adr) ? 1'b0 : 1'b0;
`endif
    endfunction

    task automatic model_apply(input logic [1:0] rw, input logic [PA_BITS-1:0] adr);
        for (int i = 0; i < BPL; i++) begin
            int a;
            a = beat_of(adr, i);
            if (rw[0]) begin
                if (!is_err(adr)) mdl_mem[a] = wr_beats[i];
            end else if (is_err(adr)) begin
                mdl_fb[i] = '0;
            end else begin
                mdl_fb[i] = mdl_mem.exists(a) ? mdl_mem[a] : 'x;
            end
        end
    endtask

    task automatic snapshot_fb();
        for (int i = 0; i < BPL; i++) obs_beats[i] = bif.FetchBuffer[i*BEATLEN +: BEATLEN];
    endtask

    // Issue one request at the current negedge and follow it to DONE and IDLE.
    // Returns at the negedge of the IDLE cycle two cycles after the ack.
    task automatic run_txn(input logic [1:0] rw, input logic [PA_BITS-1:0] adr);
        int first;
        int last;
        first         = LATENCY + 1;
        last          = LATENCY + BPL;
        obs_ack_cyc   = -1;
        obs_bc_bad    = 0;
        obs_sel_bad   = 0;
        obs_busy_bad  = 0;
        obs_extra_ack = 0;
        obs_err       = 1'b0;
        bif.CacheBusRW  = rw;
        bif.CacheBusAdr = adr;
        for (int c = 0; c <= last + 20 && obs_ack_cyc < 0; c++) begin
            logic [2:0] exp_bc;
            if (c > 0) @(negedge clk);
            exp_bc = (c < first) ? 3'd0 : 3'(c - first);
            if (bif.BusBusy !== (c > 0)) obs_busy_bad++;
            if (bif.BeatCount !== exp_bc) obs_bc_bad++;
            if (bif.SelBusBeat !== (rw[0] && c >= first && c <= last)) obs_sel_bad++;
            if (bif.CacheBusAck === 1'b1) begin
                obs_ack_cyc = c;
`ifdef CACHE_RESP_ERR_EN
                obs_err = bif.BusErr;
`endif
            end
        end
        @(negedge clk);  // DONE: cache drops its request
        if (bif.CacheBusAck !== 1'b0) obs_extra_ack++;
        obs_done_bc    = int'(bif.BeatCount);
        bif.CacheBusRW = 2'b00;
        snapshot_fb();
        @(negedge clk);  // IDLE
        if (bif.CacheBusAck !== 1'b0) obs_extra_ack++;
        if (bif.BusBusy !== 1'b0) obs_busy_bad++;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bif.CacheBusRW  = 2'b00;
        bif.CacheBusAdr = '0;
        bif.FlushStage  = 1'b0;
        for (int i = 0; i < BPL; i++) wr_beats[i] = '0;
        repeat (3) @(negedge clk);
        asserts++; if (bif.BusBusy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", bif.BusBusy); end
        asserts++; if (bif.BeatCount !== 3'd0) begin fails++; $display("FAIL reset_beatcount: got %0d want 0", bif.BeatCount); end
        asserts++; if (bif.SelBusBeat !== 1'b0) begin fails++; $display("FAIL reset_sel: got %b want 0", bif.SelBusBeat); end
        asserts++; if (bif.CacheBusAck !== 1'b0) begin fails++; $display("FAIL reset_ack: got %b want 0", bif.CacheBusAck); end
        asserts++; if (bif.FetchBuffer !== '0) begin fails++; $display("FAIL reset_fetchbuf: got %h want 0", bif.FetchBuffer); end
`ifdef CACHE_RESP_ERR_EN
        asserts++; if (bif.BusErr !== 1'b0) begin fails++; $display("FAIL reset_buserr: got %b want 0", bif.BusErr); end
`endif
        reset = 1'b0;
        for (int i = 0; i < BPL; i++) mdl_fb[i] = '0;
        @(negedge clk);
        asserts++; if (bif.BusBusy !== 1'b0) begin fails++; $display("FAIL reset_release_busy: got %b want 0", bif.BusBusy); end
    endtask

    task automatic test_read_fetch();
        // Preload beats 8..15 with 0x1000+beat via a writeback to line 1.
        for (int i = 0; i < BPL; i++) wr_beats[i] = 64'h1008 + 64'(i);
        run_txn(2'b01, 32'h40);
        model_apply(2'b01, 32'h40);
        for (int i = 0; i < BPL; i++) wr_beats[i] = 64'hDEAD_0000 + 64'(i);
        run_txn(2'b10, 32'h40);
        model_apply(2'b10, 32'h40);
        asserts++; if (obs_ack_cyc != ACK_CYC) begin fails++; $display("FAIL read_ack_cycle: got %0d want %0d", obs_ack_cyc, ACK_CYC); end
        asserts++; if (obs_bc_bad != 0) begin fails++; $display("FAIL read_beatcount_seq: %0d wrong cycles, want 0", obs_bc_bad); end
        asserts++; if (obs_sel_bad != 0) begin fails++; $display("FAIL read_sel: %0d wrong cycles, want 0", obs_sel_bad); end
        asserts++; if (obs_busy_bad != 0) begin fails++; $display("FAIL read_busy: %0d wrong cycles, want 0", obs_busy_bad); end
        asserts++; if (obs_done_bc != 0) begin fails++; $display("FAIL read_done_beatcount: got %0d want 0", obs_done_bc); end
        for (int i = 0; i < BPL; i++) begin
            asserts++;
            if (obs_beats[i] !== mdl_fb[i]) begin fails++; $display("FAIL read_beat%0d: got %h want %h", i, obs_beats[i], mdl_fb[i]); end
        end
    endtask

    task automatic test_writeback();
        logic [BEATLEN-1:0] fb_before [BPL];
        for (int i = 0; i < BPL; i++) begin
            wr_beats[i]  = 64'hA0 + 64'(i);
            fb_before[i] = mdl_fb[i];
        end
        run_txn(2'b01, 32'h80);
        model_apply(2'b01, 32'h80);
        asserts++; if (obs_ack_cyc != ACK_CYC) begin fails++; $display("FAIL wb_ack_cycle: got %0d want %0d", obs_ack_cyc, ACK_CYC); end
        asserts++; if (obs_sel_bad != 0) begin fails++; $display("FAIL wb_sel_window: %0d wrong cycles, want 0", obs_sel_bad); end
        asserts++; if (obs_extra_ack != 0) begin fails++; $display("FAIL wb_extra_ack: got %0d want 0", obs_extra_ack); end
        for (int i = 0; i < BPL; i++) begin
            asserts++;
            if (obs_beats[i] !== fb_before[i]) begin fails++; $display("FAIL wb_fetchbuf_hold%0d: got %h want %h", i, obs_beats[i], fb_before[i]); end
        end
        run_txn(2'b10, 32'h80);
        model_apply(2'b10, 32'h80);
        for (int i = 0; i < BPL; i++) begin
            asserts++;
            if (obs_beats[i] !== mdl_fb[i]) begin fails++; $display("FAIL wb_readback%0d: got %h want %h", i, obs_beats[i], mdl_fb[i]); end
        end
    endtask

    task automatic test_priority_back_to_back();
        logic [BEATLEN-1:0] fb_before [BPL];
        for (int i = 0; i < BPL; i++) begin
            wr_beats[i]  = {$urandom, $urandom};
            fb_before[i] = mdl_fb[i];
        end
        run_txn(2'b11, 32'hC0);
        model_apply(2'b11, 32'hC0);
        asserts++; if (obs_sel_bad != 0) begin fails++; $display("FAIL prio_is_write: %0d wrong sel cycles, want 0", obs_sel_bad); end
        asserts++; if (obs_extra_ack != 0) begin fails++; $display("FAIL prio_single_ack: %0d extra acks, want 0", obs_extra_ack); end
        for (int i = 0; i < BPL; i++) begin
            asserts++;
            if (obs_beats[i] !== fb_before[i]) begin fails++; $display("FAIL prio_no_fetch%0d: got %h want %h", i, obs_beats[i], fb_before[i]); end
        end
        // Re-request the fetch two cycles after the ack.
        run_txn(2'b10, 32'hC0);
        model_apply(2'b10, 32'hC0);
        asserts++; if (obs_ack_cyc != ACK_CYC) begin fails++; $display("FAIL b2b_ack_cycle: got %0d want %0d", obs_ack_cyc, ACK_CYC); end
        for (int i = 0; i < BPL; i++) begin
            asserts++;
            if (obs_beats[i] !== mdl_fb[i]) begin fails++; $display("FAIL b2b_beat%0d: got %h want %h", i, obs_beats[i], mdl_fb[i]); end
        end
    endtask

    task automatic test_abort();
        int acks;
        acks = 0;
        bif.CacheBusRW  = 2'b10;
        bif.CacheBusAdr = 32'h40;
        @(negedge clk);  // first WAIT cycle
        asserts++; if (bif.BusBusy !== 1'b1) begin fails++; $display("FAIL abort_in_wait: busy got %b want 1", bif.BusBusy); end
        bif.FlushStage = 1'b1;
        bif.CacheBusRW = 2'b00;
        @(negedge clk);
        bif.FlushStage = 1'b0;
        asserts++; if (bif.BusBusy !== 1'b0) begin fails++; $display("FAIL abort_to_idle: busy got %b want 0", bif.BusBusy); end
        for (int c = 0; c < ACK_CYC + 4; c++) begin
            if (bif.CacheBusAck !== 1'b0) acks++;
            @(negedge clk);
        end
        asserts++; if (acks != 0) begin fails++; $display("FAIL abort_no_ack: got %0d acks want 0", acks); end
        snapshot_fb();
        for (int i = 0; i < BPL; i++) begin
            asserts++;
            if (obs_beats[i] !== mdl_fb[i]) begin fails++; $display("FAIL abort_fetchbuf%0d: got %h want %h", i, obs_beats[i], mdl_fb[i]); end
        end
    endtask

    task automatic test_reset_mid_burst();
        int acks;
        acks = 0;
        bif.CacheBusRW  = 2'b10;
        bif.CacheBusAdr = 32'h40;
        for (int c = 1; c <= LATENCY + 1 + 3; c++) begin
            @(negedge clk);
            if (bif.CacheBusAck !== 1'b0) acks++;
        end
        asserts++; if (bif.BeatCount !== 3'd3) begin fails++; $display("FAIL midrst_at_beat3: got %0d want 3", bif.BeatCount); end
        reset = 1'b1;
        bif.CacheBusRW = 2'b00;
        @(negedge clk);
        if (bif.CacheBusAck !== 1'b0) acks++;
        asserts++; if (bif.BusBusy !== 1'b0) begin fails++; $display("FAIL midrst_idle: busy got %b want 0", bif.BusBusy); end
        asserts++; if (bif.BeatCount !== 3'd0) begin fails++; $display("FAIL midrst_beatcount: got %0d want 0", bif.BeatCount); end
        asserts++; if (bif.FetchBuffer !== '0) begin fails++; $display("FAIL midrst_fetchbuf: got %h want 0", bif.FetchBuffer); end
        asserts++; if (acks != 0) begin fails++; $display("FAIL midrst_no_ack: got %0d acks want 0", acks); end
        reset = 1'b0;
        for (int i = 0; i < BPL; i++) mdl_fb[i] = '0;
        @(negedge clk);
        run_txn(2'b10, 32'h80);
        model_apply(2'b10, 32'h80);
        asserts++; if (obs_ack_cyc != ACK_CYC) begin fails++; $display("FAIL midrst_refetch_ack: got %0d want %0d", obs_ack_cyc, ACK_CYC); end
        for (int i = 0; i < BPL; i++) begin
            asserts++;
            if (obs_beats[i] !== mdl_fb[i]) begin fails++; $display("FAIL midrst_refetch%0d: got %h want %h", i, obs_beats[i], mdl_fb[i]); end
        end
    endtask

    task automatic test_wrap();
        logic [PA_BITS-1:0] far_adr;
        far_adr = PA_BITS'(MEMBEATS * (BEATLEN / 8));
        for (int i = 0; i < BPL; i++) wr_beats[i] = {$urandom, $urandom};
        run_txn(2'b01, '0);
        model_apply(2'b01, '0);
        run_txn(2'b10, far_adr);
        model_apply(2'b10, far_adr);
        asserts++; if (obs_ack_cyc != ACK_CYC) begin fails++; $display("FAIL wrap_ack_cycle: got %0d want %0d", obs_ack_cyc, ACK_CYC); end
`ifdef CACHE_RESP_ERR_EN
        asserts++; if (obs_err !== 1'b1) begin fails++; $display("FAIL wrap_buserr: got %b want 1", obs_err); end
`endif
        for (int i = 0; i < BPL; i++) begin
            asserts++;
            if (obs_beats[i] !== mdl_fb[i]) begin fails++; $display("FAIL wrap_beat%0d: got %h want %h", i, obs_beats[i], mdl_fb[i]); end
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 20; n++) begin
            int                 line;
            int                 k;
            logic [1:0]         rw;
            logic [PA_BITS-1:0] adr;
            line = ($urandom_range(0, 3) == 0) ? (MEMBEATS / BPL + int'($urandom_range(0, 7)))
                                               : int'($urandom_range(0, 7));
            adr  = PA_BITS'(line * LINE_BYTES + int'($urandom_range(0, LINE_BYTES - 1)));
            k    = int'($urandom_range(0, 2));
            rw   = (k == 0) ? 2'b01 : (k == 1) ? 2'b10 : 2'b11;
            for (int i = 0; i < BPL; i++) wr_beats[i] = {$urandom, $urandom};
            run_txn(rw, adr);
            model_apply(rw, adr);
            asserts++; if (obs_ack_cyc != ACK_CYC) begin fails++; $display("FAIL rnd%0d_ack_cycle: got %0d want %0d", n, obs_ack_cyc, ACK_CYC); end
`ifdef CACHE_RESP_ERR_EN
            asserts++; if (obs_err !== is_err(adr)) begin fails++; $display("FAIL rnd%0d_buserr: got %b want %b", n, obs_err, is_err(adr)); end
`endif
            if (rw == 2'b10) begin
                for (int i = 0; i < BPL; i++) begin
                    if (!$isunknown(mdl_fb[i])) begin
                        asserts++;
                        if (obs_beats[i] !== mdl_fb[i]) begin fails++; $display("FAIL rnd%0d_beat%0d: got %h want %h", n, i, obs_beats[i], mdl_fb[i]); end
                    end
                end
            end else begin
                asserts++; if (obs_sel_bad != 0) begin fails++; $display("FAIL rnd%0d_sel: %0d wrong cycles, want 0", n, obs_sel_bad); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_read_fetch();
        test_writeback();
        test_priority_back_to_back();
        test_abort();
        test_reset_mid_burst();
        test_wrap();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, %0d failures so far", fails);
        $fatal(1, "watchdog expired");
    end
endmodule
